load_store_unit: RTL and testbench

Load/store unit sitting directly downstream of the ALU in the RISC-V datapath. It takes ALUResult as the effective address and RD2 as store data, and runs one access per instruction on a simple req/ack memory bus. While the access is outstanding it stalls the core. It returns sign- or zero-extended ReadData to the writeback mux and flags misaligned or illegal accesses and bus timeouts.

---
 rtl/load_store_unit.sv | 145 ++++++++++++++
 tb/tb_load_store_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns ALU address and RD2 into one req/ack bus access,
// stalling the core until the access completes or times out.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  off;
    logic [2:0]  f3;

    logic        is_load;
    logic        is_store;
    logic        any_req;
    logic        f3_ok;
    logic        aligned;
    logic        valid_req;
    logic [3:0]  be_next;
    logic [31:0] wd_next;
    logic [31:0] lane;
    logic [31:0] load_val;

    assign is_load  = mem_read & ~mem_write;
    assign is_store = mem_write & ~mem_read;
    assign any_req  = mem_read | mem_write;

    always_comb begin
        f3_ok   = 1'b0;
        aligned = 1'b0;
        be_next = 4'b1111;
        wd_next = wdata;
        unique case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok = is_load | is_store;
            3'b100, 3'b101:         f3_ok = is_load;
            default:                f3_ok = 1'b0;
        endcase
        unique case (funct3[1:0])
            2'b00: begin
                aligned = 1'b1;
                be_next = 4'b0001 << addr[1:0];
                wd_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                aligned = ~addr[0];
                be_next = 4'b0011 << addr[1:0];
                wd_next = {2{wdata[15:0]}};
            end
            2'b10: aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign valid_req = f3_ok & aligned;

    assign fault = ~reset & (state == IDLE) & any_req & ~valid_req;
    assign stall = ~reset & (((state == IDLE) & valid_req) | (state == WAIT));

    // Select the addressed lane first, then extend per the captured size.
    assign lane = bus_rdata >> {off, 3'b000};

    always_comb begin
        load_val = lane;
        unique case (f3)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'd0, lane[7:0]};
            3'b101:  load_val = {16'd0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            off       <= 2'd0;
            f3        <= 3'd0;
            rdata     <= 32'd0;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus_err <= 1'b0;
                    if (valid_req) begin
                        state     <= WAIT;
                        cnt       <= 8'd0;
                        off       <= addr[1:0];
                        f3        <= funct3;
                        bus_req   <= 1'b1;
                        bus_we    <= is_store;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= be_next;
                        bus_wdata <= wd_next;
                    end
                end
                WAIT: begin
                    if (bus_ack) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        if (!bus_we) rdata <= load_val;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (!bus_we) rdata <= 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    bus_err <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random accesses checked
// against an arithmetic model of sizes, lanes and extension.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] exp_rdata;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .fault(fault),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int size_of(input logic [2:0] f);
        if (f[1:0] == 2'b00) return 1;
        if (f[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_valid(input bit rd, input bit wr,
                                       input logic [2:0] f, input logic [31:0] a);
        bit legal;
        if (rd == wr) return 0;
        if (rd) legal = (f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
        else    legal = (f == 0 || f == 1 || f == 2);
        return legal && ((a % size_of(f)) == 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f,
                                               input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * (a % 4));
        case (f)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    // d = wait cycles before ack; d >= TMO means no ack at all.
    task automatic access(input bit ld, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] word, input int d);
        int sz;
        bit last;
        bit timed;
        logic [3:0]  be;
        logic [31:0] bwd;
        sz  = size_of(f);
        be  = 4'(((1 << sz) - 1) << (a % 4));
        bwd = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
              (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        mem_read = ld; mem_write = !ld; funct3 = f; addr = a; wdata = wd;
        bus_ack = 1'b0; bus_rdata = $urandom;
        #1;
        check("idle_stall", {31'd0, stall}, 32'd1);
        check("idle_fault", {31'd0, fault}, 32'd0);
        tick;
        for (int k = 0; k < TMO; k++) begin
            check("wait_req",   {31'd0, bus_req}, 32'd1);
            check("wait_stall", {31'd0, stall},   32'd1);
            check("wait_fault", {31'd0, fault},   32'd0);
            check("wait_we",    {31'd0, bus_we},  {31'd0, !ld});
            check("wait_addr",  bus_addr, a & 32'hFFFFFFFC);
            check("wait_be",    {28'd0, bus_be}, {28'd0, be});
            check("wait_wdata", bus_wdata, bwd);
            bus_ack   = (k == d);
            bus_rdata = (k == d) ? word : $urandom;
            last = (k == d) || (k == TMO - 1);
            tick;
            if (last) break;
        end
        timed = (d >= TMO);
        if (ld) exp_rdata = timed ? 32'd0 : model_load(f, a, word);
        check("done_stall", {31'd0, stall},   32'd0);
        check("done_req",   {31'd0, bus_req}, 32'd0);
        check("done_err",   {31'd0, bus_err}, {31'd0, timed});
        check("done_rdata", rdata, exp_rdata);
        bus_ack = 1'b1; bus_rdata = $urandom;
        mem_read = 1'b0; mem_write = 1'b0;
        tick;
        check("back_stall", {31'd0, stall},   32'd0);
        check("back_err",   {31'd0, bus_err}, 32'd0);
        check("back_req",   {31'd0, bus_req}, 32'd0);
        check("back_rdata", rdata, exp_rdata);
        bus_ack = 1'b0;
    endtask

    task automatic fault_req(input bit rd, input bit wr, input logic [2:0] f,
                             input logic [31:0] a);
        mem_read = rd; mem_write = wr; funct3 = f; addr = a; wdata = $urandom;
        #1;
        check("flt_fault", {31'd0, fault}, 32'd1);
        check("flt_stall", {31'd0, stall}, 32'd0);
        tick;
        check("flt_req",    {31'd0, bus_req}, 32'd0);
        check("flt_fault2", {31'd0, fault},   32'd1);
        check("flt_rdata",  rdata, exp_rdata);
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        check("flt_clear", {31'd0, fault}, 32'd0);
    endtask

    initial begin
        bit rd;
        bit wr;
        logic [2:0]  f;
        logic [31:0] a;
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        exp_rdata = 32'd0;
        tick;
        mem_read = 1'b1; funct3 = 3'd2; addr = 32'h101;
        #1;
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        tick;
        check("rst_rdata", rdata, 32'd0);
        check("rst_req",   {31'd0, bus_req}, 32'd0);
        check("rst_addr",  bus_addr, 32'd0);
        check("rst_be",    {28'd0, bus_be}, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_err",   {31'd0, bus_err}, 32'd0);
        mem_read = 1'b0;
        reset = 1'b0;
        tick;

        access(1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        access(1, 3'b000, 32'h203, 32'h0, 32'h80FF0000, 0);
        check("lb_value", rdata, 32'hFFFFFF80);
        access(1, 3'b100, 32'h203, 32'h0, 32'h80FF0000, 1);
        check("lbu_value", rdata, 32'h00000080);
        access(0, 3'b001, 32'h102, 32'h1234ABCD, 32'h5555AAAA, 3);
        check("sh_keeps", rdata, 32'h00000080);
        fault_req(1, 0, 3'b010, 32'h101);
        fault_req(0, 1, 3'b100, 32'h100);
        fault_req(1, 1, 3'b000, 32'h100);
        access(1, 3'b010, 32'h400, 32'h0, 32'h12345678, TMO);
        check("tmo_rdata", rdata, 32'd0);
        access(1, 3'b101, 32'h402, 32'h0, 32'hBEEF1234, 2);

        // Reset during the second wait cycle, then a stray ack.
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h300;
        tick;
        check("rw_req1", {31'd0, bus_req}, 32'd1);
        tick;
        check("rw_req2", {31'd0, bus_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("rw_stall", {31'd0, stall}, 32'd0);
        check("rw_fault", {31'd0, fault}, 32'd0);
        tick;
        reset = 1'b0; mem_read = 1'b0;
        exp_rdata = 32'd0;
        #1;
        check("rw_req", {31'd0, bus_req}, 32'd0);
        check("rw_stall2", {31'd0, stall}, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick;
        check("rw_ack_rdata", rdata, 32'd0);
        check("rw_ack_req", {31'd0, bus_req}, 32'd0);
        bus_ack = 1'b0;
        tick;

        for (int i = 0; i < 60; i++) begin
            rd = 1'($urandom % 2);
            wr = !rd;
            if ($urandom % 8 == 0) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            f = 3'($urandom);
            a = $urandom;
            if ($urandom % 2 == 1) a[1:0] = 2'b00;
            if (model_valid(rd, wr, f, a))
                access(rd, f, a, $urandom, $urandom, int'($urandom % 6));
            else
                fault_req(rd, wr, f, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
